// File: rtl/ntt_mdc_pkg.sv
// Shared types and helpers for the MDC NTT pipeline blocks.
package ntt_mdc_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    READ  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } feeder_state_t;

  // Reverse the low `width` bits of `value`; bits above `width` are cleared.
  function automatic logic [31:0] bitrev(input int unsigned width, input logic [31:0] value);
    logic [31:0] r;
    r = '0;
    for (int unsigned b = 0; b < width; b++) begin
      r[width-1-b] = value[b];
    end
    return r;
  endfunction

endpackage

// File: rtl/ntt_mdc_feeder_shiftreg.sv
// Fixed-depth delay line with synchronous clear.
module shiftreg #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH-1:0] pipe [DEPTH];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int unsigned k = 0; k < DEPTH; k++) pipe[k] <= '0;
    end else begin
      pipe[0] <= din;
      for (int unsigned k = 1; k < DEPTH; k++) pipe[k] <= pipe[k-1];
    end
  end

  assign dout = pipe[DEPTH-1];

endmodule

// File: rtl/ntt_mdc_feeder.sv
// Reads one polynomial from a dual-port BRAM and streams it as N/2 coefficient
// pairs into the first MDC stage, in GS (DIF) or CT (DIT) pairing order.
module ntt_mdc_feeder
  import ntt_mdc_pkg::*;
#(
  parameter int LOGQ       = 64,
  parameter int LOGN       = 4,
  parameter int BTF_GS     = 1,
  parameter int DELAY_BRAM = 2
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            go,
  input  logic            intt_in,
  output logic            busy,
  output logic            done,
  output logic            mem_rd_en,
  output logic [LOGN-1:0] mem_raddr_0,
  output logic [LOGN-1:0] mem_raddr_1,
  input  logic [LOGQ-1:0] mem_rdata_0,
  input  logic [LOGQ-1:0] mem_rdata_1,
  output logic            start,
  output logic            intt,
  output logic [LOGQ-1:0] stage_in_0,
  output logic [LOGQ-1:0] stage_in_1
);

  localparam int N_HALF = 2**(LOGN-1);
  localparam int DW     = (DELAY_BRAM > 1) ? $clog2(DELAY_BRAM) : 1;

  feeder_state_t   state, state_next;
  logic [LOGN-2:0] beat;
  logic [DW-1:0]   drain_cnt;
  logic            intt_q;
  logic            valid;
  logic [LOGN-1:0] addr_0, addr_1;

  always_comb begin
    state_next = state;
    busy       = 1'b0;
    done       = 1'b0;
    mem_rd_en  = 1'b0;
    case (state)
      IDLE: if (go) state_next = READ;
      READ: begin
        busy      = 1'b1;
        mem_rd_en = 1'b1;
        if (beat == (LOGN-1)'(N_HALF-1)) state_next = DRAIN;
      end
      DRAIN: begin
        busy = 1'b1;
        if (drain_cnt == DW'(DELAY_BRAM-1)) state_next = DONE;
      end
      DONE: begin
        busy       = 1'b1;
        done       = 1'b1;
        state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      beat      <= '0;
      drain_cnt <= '0;
      intt_q    <= 1'b0;
    end else begin
      state <= state_next;
      if (state == IDLE && go) intt_q <= intt_in;
      // beat is N/2-modular, so it is back at 0 when READ ends
      if (state == READ) beat <= beat + 1'b1;
      if (state == DRAIN) begin
        drain_cnt <= (drain_cnt == DW'(DELAY_BRAM-1)) ? '0 : drain_cnt + 1'b1;
      end
    end
  end

  generate
    if (BTF_GS != 0) begin : g_gs
      assign addr_0 = {1'b0, beat};
      assign addr_1 = {1'b1, beat};
    end else begin : g_ct
      assign addr_0 = LOGN'(bitrev(LOGN, 32'({1'b0, beat})));
      assign addr_1 = LOGN'(bitrev(LOGN, 32'({1'b1, beat})));
    end
  endgenerate

  assign mem_raddr_0 = mem_rd_en ? addr_0 : '0;
  assign mem_raddr_1 = mem_rd_en ? addr_1 : '0;

  shiftreg #(
    .WIDTH (1),
    .DEPTH (DELAY_BRAM)
  ) u_valid (
    .clk  (clk),
    .rst  (rst),
    .din  (mem_rd_en),
    .dout (valid)
  );

  assign start      = valid;
  assign intt       = intt_q;
  assign stage_in_0 = valid ? mem_rdata_0 : '0;
  assign stage_in_1 = valid ? mem_rdata_1 : '0;

endmodule

// File: tb/tb_ntt_mdc_feeder.sv
// Directed bench: GS and CT feeders side by side, each with a 2-cycle BRAM holding k+100.
module tb_ntt_mdc_feeder;

  localparam int LOGQ = 64;
  localparam int LOGN = 4;

  logic clk = 1'b0;
  logic rst, go, intt_in;

  logic            busy_gs, done_gs, rd_gs, start_gs, intt_gs;
  logic [LOGN-1:0] a0_gs, a1_gs;
  logic [LOGQ-1:0] rd0_gs, rd1_gs, s0_gs, s1_gs;
  logic            busy_ct, done_ct, rd_ct, start_ct, intt_ct;
  logic [LOGN-1:0] a0_ct, a1_ct;
  logic [LOGQ-1:0] rd0_ct, rd1_ct, s0_ct, s1_ct;

  logic [LOGQ-1:0] p0_gs, p1_gs, p0_ct, p1_ct;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ntt_mdc_feeder #(.LOGQ(LOGQ), .LOGN(LOGN), .BTF_GS(1), .DELAY_BRAM(2)) dut_gs (
    .clk(clk), .rst(rst), .go(go), .intt_in(intt_in),
    .busy(busy_gs), .done(done_gs), .mem_rd_en(rd_gs),
    .mem_raddr_0(a0_gs), .mem_raddr_1(a1_gs),
    .mem_rdata_0(rd0_gs), .mem_rdata_1(rd1_gs),
    .start(start_gs), .intt(intt_gs), .stage_in_0(s0_gs), .stage_in_1(s1_gs)
  );

  ntt_mdc_feeder #(.LOGQ(LOGQ), .LOGN(LOGN), .BTF_GS(0), .DELAY_BRAM(2)) dut_ct (
    .clk(clk), .rst(rst), .go(go), .intt_in(intt_in),
    .busy(busy_ct), .done(done_ct), .mem_rd_en(rd_ct),
    .mem_raddr_0(a0_ct), .mem_raddr_1(a1_ct),
    .mem_rdata_0(rd0_ct), .mem_rdata_1(rd1_ct),
    .start(start_ct), .intt(intt_ct), .stage_in_0(s0_ct), .stage_in_1(s1_ct)
  );

  // Two-stage BRAM read pipeline, contents mem[k] = k + 100
  always @(posedge clk) begin
    p0_gs  <= 64'(a0_gs) + 64'd100;
    p1_gs  <= 64'(a1_gs) + 64'd100;
    rd0_gs <= p0_gs;
    rd1_gs <= p1_gs;
    p0_ct  <= 64'(a0_ct) + 64'd100;
    p1_ct  <= 64'(a1_ct) + 64'd100;
    rd0_ct <= p0_ct;
    rd1_ct <= p1_ct;
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    int ct_ord [8];
    int p, f, b, d, starts, dones;
    logic exp_intt;
    ct_ord = '{0, 8, 4, 12, 2, 10, 6, 14};

    rst = 1'b1; go = 1'b0; intt_in = 1'b0;
    tick(); tick();
    check("rst_busy", 64'(busy_gs), 64'd0);
    check("rst_done", 64'(done_gs), 64'd0);
    check("rst_rd_en", 64'(rd_gs), 64'd0);
    check("rst_start", 64'(start_gs), 64'd0);
    check("rst_intt", 64'(intt_gs), 64'd0);
    check("rst_addr0", 64'(a0_ct), 64'd0);
    check("rst_addr1", 64'(a1_gs), 64'd0);
    check("rst_stage0", s0_gs, 64'd0);
    rst = 1'b0;
    tick();

    // Three back-to-back frames; go also pulsed at p=5 and p=11 while busy
    go = 1'b1; intt_in = 1'b1;
    tick();
    starts = 0; dones = 0;
    for (int t = 1; t <= 36; t++) begin
      p = (t - 1) % 12 + 1;
      f = (t - 1) / 12;
      b = p - 1;
      d = p - 3;
      exp_intt = (f != 1);
      check("busy", 64'(busy_gs), 64'(p <= 11));
      check("done", 64'(done_gs), 64'(p == 11));
      check("done_ct", 64'(done_ct), 64'(p == 11));
      check("rd_en", 64'(rd_gs), 64'(p <= 8));
      check("start", 64'(start_gs), 64'(p >= 3 && p <= 10));
      check("start_ct", 64'(start_ct), 64'(p >= 3 && p <= 10));
      check("intt", 64'(intt_gs), 64'(exp_intt));
      if (p <= 8) begin
        check("gs_addr0", 64'(a0_gs), 64'(b));
        check("gs_addr1", 64'(a1_gs), 64'(b + 8));
        check("ct_addr0", 64'(a0_ct), 64'(ct_ord[b]));
        check("ct_addr1", 64'(a1_ct), 64'(ct_ord[b] + 1));
      end else begin
        check("idle_addr0", 64'(a0_gs), 64'd0);
        check("idle_addr1", 64'(a1_ct), 64'd0);
      end
      if (p >= 3 && p <= 10) begin
        check("gs_lane0", s0_gs, 64'(100 + d));
        check("gs_lane1", s1_gs, 64'(108 + d));
        check("ct_lane0", s0_ct, 64'(100 + ct_ord[d]));
        check("ct_lane1", s1_ct, 64'(101 + ct_ord[d]));
      end else begin
        check("mask_lane0", s0_gs, 64'd0);
        check("mask_lane1", s1_ct, 64'd0);
      end
      if (start_gs) starts++;
      if (done_gs) dones++;
      go = (p == 5) || (p == 11) || (p == 12 && f < 2);
      if (p == 2 && f == 0) intt_in = 1'b0;
      if (p == 12 && f == 1) intt_in = 1'b1;
      tick();
    end
    check("b2b_starts", 64'(starts), 64'd24);
    check("b2b_dones", 64'(dones), 64'd3);

    // Mid-frame reset: rst during T5 clears everything at T6
    go = 1'b1; intt_in = 1'b1;
    tick();
    go = 1'b0;
    tick(); tick(); tick(); tick();
    rst = 1'b1;
    tick();
    check("abort_busy", 64'(busy_gs), 64'd0);
    check("abort_start", 64'(start_gs), 64'd0);
    check("abort_rd_en", 64'(rd_gs), 64'd0);
    check("abort_stage0", s0_gs, 64'd0);
    check("abort_stage1", s1_ct, 64'd0);
    check("abort_intt", 64'(intt_gs), 64'd0);
    rst = 1'b0;
    dones = 0; starts = 0;
    for (int t = 0; t < 12; t++) begin
      tick();
      if (done_gs) dones++;
      if (start_gs) starts++;
    end
    check("abort_no_done", 64'(dones), 64'd0);
    check("abort_no_start", 64'(starts), 64'd0);

    go = 1'b1; intt_in = 1'b0;
    tick();
    go = 1'b0;
    starts = 0; dones = 0;
    for (int t = 1; t <= 14; t++) begin
      if (t == 3) begin
        check("post_first_start", 64'(start_gs), 64'd1);
        check("post_first_lane0", s0_gs, 64'd100);
        check("post_first_lane1", s1_gs, 64'd108);
      end
      if (start_gs) starts++;
      if (done_gs) dones++;
      tick();
    end
    check("post_starts", 64'(starts), 64'd8);
    check("post_dones", 64'(dones), 64'd1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/ntt_mdc_feeder.md
Name: ntt_mdc_feeder

Overview:
Source end of the MDC NTT pipeline. It reads one N-coefficient polynomial from a dual-port coefficient BRAM and emits it as the two-lane stream (start, stage_in_0, stage_in_1) that the first ntt_mdc_stage consumes. It runs N/2 contiguous beats per frame, in DIF (GS) or DIT (CT) pairing order.

Parameters:
LOGQ, 64, coefficient width in bits
LOGN, 4, log2 of the polynomial length N
BTF_GS, 1, 1 = GS/DIF pairing; 0 = CT/DIT bit-reversed pairing
DELAY_BRAM, 2, BRAM read latency in cycles from address to data; legal range >= 1

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
go  in  1  frame request; accepted only in IDLE
intt_in  in  1  frame mode; sampled when go is accepted
busy  out  1  frame in progress
done  out  1  one-cycle pulse after the last beat
mem_rd_en  out  1  BRAM read enable, both ports
mem_raddr_0  out  LOGN  read address, port A
mem_raddr_1  out  LOGN  read address, port B
mem_rdata_0  in  LOGQ  read data, port A
mem_rdata_1  in  LOGQ  read data, port B
start  out  1  beat valid to stage 0, one per data pair
intt  out  1  latched frame mode, held for the whole frame
stage_in_0  out  LOGQ  lane-0 coefficient
stage_in_1  out  LOGQ  lane-1 coefficient

Behaviour:
- Reset (synchronous, active-high):
  - Outputs busy, done, mem_rd_en, start and intt are 0.
  - Addresses and stage_in_* are 0.
  - The beat counter is 0 and the valid shift register is cleared.
  - Reset mid-frame aborts the frame; no further start and no done are emitted.
- FSM states: IDLE, READ, DRAIN, DONE.
  - IDLE -> READ: go=1 at edge T0. intt_in is latched into intt at that edge.
  - READ: lasts exactly N/2 cycles, T1..T(N/2). mem_rd_en=1. Beat counter i runs 0..N/2-1 (LOGN-1 bits; wraps to 0 on exit).
  - READ -> DRAIN: after beat N/2-1.
  - DRAIN: lasts DELAY_BRAM cycles.
  - DONE: 1 cycle with done=1, then -> IDLE.
- busy = 1 in READ, DRAIN and DONE.
- Addressing:
  - BTF_GS=1: mem_raddr_0 = i, mem_raddr_1 = i + N/2.
  - BTF_GS=0: mem_raddr_0 = bitrev_LOGN(i), mem_raddr_1 = bitrev_LOGN(i + N/2), i.e. mem_raddr_0 | 1.
  - Outside READ, both addresses are 0.
- Alignment:
  - mem_rd_en is delayed by a DELAY_BRAM-deep shift register to form start.
  - stage_in_0/1 = mem_rdata_0/1 registered-through (no extra register); valid exactly when start=1, zero-masked when start=0.
  - start is high for exactly N/2 contiguous cycles, T(1+DELAY_BRAM)..T(N/2+DELAY_BRAM).
  - done is high at T(N/2+DELAY_BRAM+1).
- intt output: holds the latched value from go-accept until the cycle after done; it then keeps its value (not cleared) until the next accept.
- go while busy (including the DONE cycle) is ignored with no side effects. go on the cycle after DONE is accepted, so the minimum frame-to-frame gap is one IDLE cycle.
- No backpressure: downstream must accept every start beat.

Decomposition:
- Shared package ntt_mdc_pkg: function bitrev(width, value); localparam N_HALF = 2**(LOGN-1); FSM state encoding.
- Sub-module: reuse the existing shiftreg for the DELAY_BRAM valid delay. No other sub-module.

Test Plan:
All scenarios use LOGN=4, DELAY_BRAM=2, with BRAM model mem[k] = k + 100.
1. GS frame: BTF_GS=1, go at T0 -> address pairs (0,8),(1,9)..(7,15) on T1..T8; start=1 on T3..T10 with stage_in (100,108)..(107,115); done at T11; busy T1..T11.
2. CT frame: BTF_GS=0 -> address pairs in order (0,1),(8,9),(4,5),(12,13),(2,3),(10,11),(6,7),(14,15); stage_in lane values are 100 + each address.
3. Mode latch: go with intt_in=1, then intt_in=0 from T2 -> intt=1 on every start beat T3..T10.
4. Request gating: go at T0, T5 and T11 -> exactly one frame; go at T12 starts the second frame, whose first start beat is at T15.
5. Mid-frame reset: rst=1 at T5 -> at T6 busy=0, start=0, mem_rd_en=0, stage_in=0; no done pulse; next go gives a full 8-beat frame.
6. Back-to-back frames: 3 frames, each go issued on the first IDLE cycle -> 24 start beats, 3 done pulses, data order identical each frame.
